// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath and its sequential multiplier:
//   - ALU_WIDTH    : datapath width shared with the ALU (32)
//   - MUL_ITER     : number of shift-add iterations of the multiplier (32)
//   - mul_state_e  : multiplier controller states (IDLE / RUN / DONE)
//   - MUL_LAST_CNT : iteration counter value of the final shift-add step
//   - hi_nonzero() : "upper product word is non-zero" reduction helper
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned MUL_ITER  = 32;

    // Counter value during the final iteration; the counter is 5 bits wide so
    // it wraps back to zero on that same edge.
    localparam logic [4:0] MUL_LAST_CNT = 5'(MUL_ITER - 1);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // True when the upper product word is non-zero, i.e. the product does
    // not fit in a single 32-bit word.
    function automatic logic hi_nonzero(input logic [ALU_WIDTH-1:0] hi);
        return |hi;
    endfunction

endpackage

// File: rtl/add_32.sv
// -----------------------------------------------------------------------------
// add_32
// Plain 32-bit ripple-carry adder shared with the ALU datapath.
// Ports:
//   a, b      in  32 : addends
//   i_carry   in  1  : carry-in
//   o_result  out 32 : a + b + i_carry (low 32 bits)
//   o_carry   out 1  : carry-out of bit 31 (unsigned overflow)
//   overflow  out 1  : two's-complement overflow (carry into MSB ^ carry out)
// -----------------------------------------------------------------------------
module add_32
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic                 i_carry,
    output logic [ALU_WIDTH-1:0] o_result,
    output logic                 o_carry,
    output logic                 overflow
);

    logic [ALU_WIDTH:0]   carry_s;
    logic [ALU_WIDTH-1:0] sum_s;

    // Bit-serial ripple: each stage is a full adder fed by the previous carry.
    always_comb begin
        carry_s    = '0;
        sum_s      = '0;
        carry_s[0] = i_carry;
        for (int i = 0; i < ALU_WIDTH; i++) begin
            sum_s[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign o_result = sum_s;
    assign o_carry  = carry_s[ALU_WIDTH];
    assign overflow = carry_s[ALU_WIDTH] ^ carry_s[ALU_WIDTH - 1];

endmodule

// File: rtl/mul_seq_32.sv
// -----------------------------------------------------------------------------
// mul_seq_32
// Sequential 32x32 -> 64 unsigned multiplier. One shared add_32 is reused for
// 32 shift-add iterations; operands come in and the product goes out over
// valid/ready handshakes.
// Ports:
//   clk        in  1  : clock, all state updates on the rising edge
//   rst        in  1  : synchronous active-high reset
//   i_valid    in  1  : operand pair on i_a/i_b is valid
//   o_ready    out 1  : operands can be accepted (IDLE only)
//   i_a        in  32 : multiplicand
//   i_b        in  32 : multiplier
//   o_valid    out 1  : o_product is valid (DONE only)
//   i_ready    in  1  : consumer accepts the product
//   o_product  out 64 : unsigned product {acc_hi, acc_lo}
//   o_hi_nz    out 1  : upper product word non-zero (result exceeds 32 bits)
//   o_busy     out 1  : multiply in progress (RUN)
// -----------------------------------------------------------------------------
module mul_seq_32
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [ALU_WIDTH-1:0]   i_a,
    input  logic [ALU_WIDTH-1:0]   i_b,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [2*ALU_WIDTH-1:0] o_product,
    output logic                   o_hi_nz,
    output logic                   o_busy
);

    mul_state_e           state_q, state_d;
    logic [ALU_WIDTH-1:0] mcand_q, mcand_d;
    logic [ALU_WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [ALU_WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 hi_nz_q, hi_nz_d;

    logic [ALU_WIDTH-1:0] add_sum_s;
    logic                 add_cout_s;
    logic                 add_overflow_unused_s;

    // The adder always sees the running upper accumulator plus the
    // multiplicand; whether that sum is used depends on the multiplier LSB.
    add_32 u_add (
        .a        (acc_hi_q),
        .b        (mcand_q),
        .i_carry  (1'b0),
        .o_result (add_sum_s),
        .o_carry  (add_cout_s),
        .overflow (add_overflow_unused_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;

        case (state_q)
            MUL_IDLE: begin
                if (i_valid && ready_q) begin
                    // acc_lo doubles as the multiplier shift register: its
                    // consumed LSBs are replaced by product bits from the top.
                    mcand_d  = i_a;
                    acc_lo_d = i_b;
                    acc_hi_d = '0;
                    cnt_d    = 5'd0;
                    state_d  = MUL_RUN;
                end else begin
                    state_d  = MUL_IDLE;
                end
            end

            MUL_RUN: begin
                // The adder carry-out becomes the 33rd bit shifted into
                // acc_hi[31], so no product bit is lost.
                if (acc_lo_q[0]) begin
                    {acc_hi_d, acc_lo_d} = {add_cout_s, add_sum_s, acc_lo_q[ALU_WIDTH-1:1]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[ALU_WIDTH-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MUL_LAST_CNT) begin
                    state_d = MUL_DONE;
                end else begin
                    state_d = MUL_RUN;
                end
            end

            MUL_DONE: begin
                // Product registers are left untouched; they hold the result
                // until the next operand accept overwrites them.
                if (i_ready) begin
                    state_d = MUL_IDLE;
                end else begin
                    state_d = MUL_DONE;
                end
            end

            default: begin
                state_d = MUL_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state so they
        // have no combinational path from i_valid or i_ready.
        ready_d = (state_d == MUL_IDLE);
        valid_d = (state_d == MUL_DONE);
        busy_d  = (state_d == MUL_RUN);
        hi_nz_d = hi_nonzero(acc_hi_d);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= 5'd0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            hi_nz_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            hi_nz_q  <= hi_nz_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_hi_nz   = hi_nz_q;
    assign o_product = {acc_hi_q, acc_lo_q};

endmodule
